// File: rtl/fft_output_serializer.sv
// fft_output_serializer: streams a captured 6-value FFT frame as 12 bytes (low then sign-extended high).
// Define FFT_SER_HEADER_EN to prefix each frame with sync 0xA5 and an 8-bit frame counter (14 bytes).
module fft_output_serializer (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [10:0] a0_re,
   input  logic [10:0] a1_re,
   input  logic [10:0] a1_im,
   input  logic [10:0] a2_re,
   input  logic [10:0] a3_re,
   input  logic [10:0] a3_im,
   input  logic        out_ready,
   output logic [7:0]  out_data,
   output logic        out_valid,
   output logic        out_last,
   output logic        busy,
   output logic [3:0]  drop_cnt
);
   typedef enum logic {IDLE, SEND} state_t;
   state_t state;
`ifdef FFT_SER_HEADER_EN
   localparam logic [3:0] LAST = 4'd13;
   logic [7:0] fcnt;
`else
   localparam logic [3:0] LAST = 4'd11;
`endif
   logic [5:0][10:0] frame, nf;
   logic [3:0] idx, ni;
   logic [7:0] nb;
   logic hs, accept;

   function automatic logic [7:0] data_byte(input logic [5:0][10:0] f, input logic [3:0] j);
      logic [10:0] v;
      v = f[j[3:1]];
      return j[0] ? {{5{v[10]}}, v[10:8]} : v[7:0];
   endfunction

   assign hs = out_valid && out_ready;
   assign accept = load && (state == IDLE || (hs && out_last));
   assign busy = state == SEND;

   // nb is the byte that becomes visible after the next transfer or accepted load
   always_comb begin
      nf = accept ? {a3_im, a3_re, a2_re, a1_im, a1_re, a0_re} : frame;
      ni = accept ? 4'd0 : idx + 4'd1;
`ifdef FFT_SER_HEADER_EN
      // fcnt has already advanced past the frame in flight, so its counter is fcnt - 1
      nb = ni == 4'd0 ? 8'hA5 : ni == 4'd1 ? fcnt - 8'd1 : data_byte(nf, ni - 4'd2);
`else
      nb = data_byte(nf, ni);
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         frame <= '0;
         idx <= '0;
         out_data <= '0;
         out_valid <= 1'b0;
         out_last <= 1'b0;
         drop_cnt <= '0;
`ifdef FFT_SER_HEADER_EN
         fcnt <= '0;
`endif
      end else begin
         if (accept || hs) begin
            state <= (accept || !out_last) ? SEND : IDLE;
            out_valid <= accept || !out_last;
            out_last <= (accept || !out_last) && ni == LAST;
            out_data <= nb;
            idx <= ni;
            frame <= nf;
         end
         if (load && !accept && drop_cnt != 4'd15)
            drop_cnt <= drop_cnt + 4'd1;
`ifdef FFT_SER_HEADER_EN
         if (accept)
            fcnt <= fcnt + 8'd1;
`endif
      end
   end
endmodule
